// File: rtl/gen_irq_mc.sv
// gen_irq_mc: multi-channel user-interrupt generator.
// Latches one pending request per channel, arbitrates round-robin onto the
// single user-IRQ port, and retries on fail/timeout up to MAX_RETRY times.
//
// Optional build macro: GEN_IRQ_TIMEOUT_AS_ACK_EN
//   defined   -> a SEND timeout completes the request as delivered (ch_ack)
//   undefined -> a SEND timeout is treated like usr_irq_out_fail
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ch_trig[NUM_CH]   per-channel request strobe
//   ch_vec/ch_fnc     per-channel vector (12b) / function (8b), packed by channel
//   ch_busy           channel holds a pending or in-flight request
//   ch_ack/ch_fail    1-cycle completion pulses (delivered / abandoned)
//   ch_drop           1-cycle pulse: trigger discarded because channel was busy
//   usr_irq_in_*      request to the IRQ port (vec, fnc, vld)
//   usr_irq_out_*     IRQ port response (ack, fail)
module gen_irq_mc #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_trig,
  input  logic [NUM_CH*12-1:0] ch_vec,
  input  logic [NUM_CH*8-1:0]  ch_fnc,
  output logic [NUM_CH-1:0]    ch_busy,
  output logic [NUM_CH-1:0]    ch_ack,
  output logic [NUM_CH-1:0]    ch_fail,
  output logic [NUM_CH-1:0]    ch_drop,
  output logic [11:0]          usr_irq_in_vec,
  output logic [7:0]           usr_irq_in_fnc,
  output logic                 usr_irq_in_vld,
  input  logic                 usr_irq_out_ack,
  input  logic                 usr_irq_out_fail
);

  localparam int unsigned VW  = 12;
  localparam int unsigned FW  = 8;
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_busy;
  logic [NUM_CH-1:0] r_ack;
  logic [NUM_CH-1:0] r_fail;
  logic [NUM_CH-1:0] r_drop;
  logic [VW-1:0]     r_cap_vec [NUM_CH];
  logic [FW-1:0]     r_cap_fnc [NUM_CH];
  logic [CHW-1:0]    r_ptr;
  logic [CHW-1:0]    r_gnt;
  logic [TW-1:0]     r_tmo;
  logic [RW-1:0]     r_retry;
  logic [VW-1:0]     r_vec;
  logic [FW-1:0]     r_fnc;
  logic              r_vld;

  state_t            w_state_nxt;
  logic [CHW-1:0]    w_ptr_nxt;
  logic [CHW-1:0]    w_gnt_nxt;
  logic [TW-1:0]     w_tmo_nxt;
  logic [RW-1:0]     w_retry_nxt;
  logic [VW-1:0]     w_vec_nxt;
  logic [FW-1:0]     w_fnc_nxt;
  logic              w_vld_nxt;
  logic              w_done_ack;
  logic              w_done_fail;
  logic              w_retry_req;
  logic              w_tmo_hit;
  logic              w_found;
  logic [CHW-1:0]    w_sel;
  logic [CHW-1:0]    w_gnt_inc;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_busy_nxt;
  int unsigned       w_idx;

  // Round-robin search: first busy channel at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_CH;
      if (!w_found && r_busy[CHW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = CHW'(w_idx);
      end
    end
  end

  assign w_gnt_inc = (r_gnt == CHW'(NUM_CH - 1)) ? '0 : r_gnt + CHW'(1);
  assign w_gnt_oh  = NUM_CH'(1) << r_gnt;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_tmo_nxt   = r_tmo;
    w_retry_nxt = r_retry;
    w_vec_nxt   = r_vec;
    w_fnc_nxt   = r_fnc;
    w_vld_nxt   = 1'b0;
    w_done_ack  = 1'b0;
    w_done_fail = 1'b0;
    w_retry_req = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_sel;
          w_vec_nxt   = r_cap_vec[w_sel];
          w_fnc_nxt   = r_cap_fnc[w_sel];
          w_vld_nxt   = 1'b1;
          w_tmo_nxt   = '0;
          w_retry_nxt = '0;
          w_state_nxt = S_SEND;
        end
      end

      S_SEND: begin
        w_vld_nxt = 1'b1;
        w_tmo_nxt = r_tmo + TW'(1);
        // Port response beats timeout; ack beats fail.
        if (usr_irq_out_ack) begin
          w_done_ack = 1'b1;
        end
`ifdef GEN_IRQ_TIMEOUT_AS_ACK_EN
        else if (usr_irq_out_fail) begin
          w_retry_req = 1'b1;
        end else if (w_tmo_hit) begin
          w_done_ack = 1'b1;
        end
`else
        else if (usr_irq_out_fail || w_tmo_hit) begin
          w_retry_req = 1'b1;
        end
`endif
        if (w_retry_req) begin
          if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RW'(1);
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_GAP;
          end else begin
            w_done_fail = 1'b1;
          end
        end
        if (w_done_ack || w_done_fail) begin
          w_vld_nxt   = 1'b0;
          w_ptr_nxt   = w_gnt_inc;
          w_state_nxt = S_IDLE;
        end
      end

      S_GAP: begin
        w_vld_nxt   = 1'b1;
        w_tmo_nxt   = '0;
        w_state_nxt = S_SEND;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A busy channel can only be cleared by completion; an idle one only set by trigger.
  assign w_clr      = (w_done_ack || w_done_fail) ? w_gnt_oh : '0;
  assign w_busy_nxt = (r_busy & ~w_clr) | (ch_trig & ~r_busy);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= '0;
      r_ack   <= '0;
      r_fail  <= '0;
      r_drop  <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_tmo   <= '0;
      r_retry <= '0;
      r_vec   <= '0;
      r_fnc   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_done_ack ? w_gnt_oh : '0;
      r_fail  <= w_done_fail ? w_gnt_oh : '0;
      r_drop  <= ch_trig & r_busy;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_retry <= w_retry_nxt;
      r_vec   <= w_vec_nxt;
      r_fnc   <= w_fnc_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  // Per-channel capture; latched data is frozen while the channel is busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        r_cap_vec[i] <= '0;
        r_cap_fnc[i] <= '0;
      end else if (ch_trig[i] && !r_busy[i]) begin
        r_cap_vec[i] <= ch_vec[VW*i +: VW];
        r_cap_fnc[i] <= ch_fnc[FW*i +: FW];
      end
    end
  end

  assign ch_busy        = r_busy;
  assign ch_ack         = r_ack;
  assign ch_fail        = r_fail;
  assign ch_drop        = r_drop;
  assign usr_irq_in_vec = r_vec;
  assign usr_irq_in_fnc = r_fnc;
  assign usr_irq_in_vld = r_vld;

endmodule
